// File: rtl/gpu_0_command.sv
// gpu_0_command: register-staged draw commands queued in a FIFO and streamed to the rectangle generator (optional irq via GPU_CMD_IRQ_EN)
module gpu_0_command #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic        reg_read,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        se_valid,
  input  logic        se_ready,
  output logic [15:0] se_start_x,
  output logic [15:0] se_start_y,
  output logic [15:0] se_width,
  output logic [15:0] se_height,
  output logic [15:0] se_scale_x,
  output logic [15:0] se_scale_y,
  output logic        se_mirror_x,
  output logic        se_mirror_y,
  output logic [31:0] se_base_address,
  output logic [15:0] se_image_width,
  output logic [4:0]  se_ct_type,
  output logic        se_use_ct,
  output logic [15:0] se_ct_base_address,
  input  logic        pipe_idle,
  output logic        busy,
  output logic        cmd_dropped
`ifdef GPU_CMD_IRQ_EN
  , output logic      irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] full_cnt = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] sx, sy, w, h, scx, scy;
    logic [31:0] base;
    logic [15:0] iw, ctb;
    logic        mx, my, uc;
    logic [4:0]  ct;
  } cmd_t;

  cmd_t stg, head;
  cmd_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic overflow, irq_bit, commit, push, pop, drop, status_wr;
  logic [4:0] ct_in;
  logic [31:0] rd_mux;

  assign status_wr = reg_write && reg_addr == 3'd7;
  assign commit = reg_write && reg_addr == 3'd6 && stg.w != 16'd0 && stg.h != 16'd0;
  assign push = commit && count != full_cnt;
  assign drop = commit && count == full_cnt;
  assign pop = se_valid && se_ready;
  assign ct_in = reg_wdata[7:3];
  assign se_valid = count != '0;
  assign busy = se_valid | ~pipe_idle;

  assign head = mem[rd_ptr];
  assign se_start_x = head.sx;
  assign se_start_y = head.sy;
  assign se_width = head.w;
  assign se_height = head.h;
  assign se_scale_x = head.scx;
  assign se_scale_y = head.scy;
  assign se_mirror_x = head.mx;
  assign se_mirror_y = head.my;
  assign se_base_address = head.base;
  assign se_image_width = head.iw;
  assign se_use_ct = head.uc;
  assign se_ct_type = head.uc ? head.ct : 5'd16;
  assign se_ct_base_address = head.ctb;

  // Staging registers written by the CPU; illegal colour depths collapse to 16 bpp
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
      stg.scx <= 16'd1;
      stg.scy <= 16'd1;
      stg.ct <= 5'd16;
    end else if (reg_write) begin
      case (reg_addr)
        3'd0: {stg.sy, stg.sx} <= reg_wdata;
        3'd1: {stg.h, stg.w} <= reg_wdata;
        3'd2: {stg.scy, stg.scx} <= reg_wdata;
        3'd3: stg.base <= reg_wdata;
        3'd4: {stg.ctb, stg.iw} <= reg_wdata;
        3'd5: begin
          stg.mx <= reg_wdata[0];
          stg.my <= reg_wdata[1];
          stg.uc <= reg_wdata[2];
          stg.ct <= (ct_in == 5'd1 || ct_in == 5'd2 || ct_in == 5'd4 || ct_in == 5'd8 || ct_in == 5'd16) ? ct_in : 5'd16;
        end
        default: ;
      endcase
    end
  end

  // Command FIFO: commit snapshots staging at the tail, handshake pops the head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= stg;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Read-back multiplexer for the register map
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      3'd0: rd_mux = {stg.sy, stg.sx};
      3'd1: rd_mux = {stg.h, stg.w};
      3'd2: rd_mux = {stg.scy, stg.scx};
      3'd3: rd_mux = stg.base;
      3'd4: rd_mux = {stg.ctb, stg.iw};
      3'd5: rd_mux = {24'd0, stg.ct, stg.uc, stg.my, stg.mx};
      3'd7: rd_mux = {21'd0, irq_bit, overflow, 5'(count), 3'd0, busy};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, drop pulse and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rdata <= '0;
      cmd_dropped <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cmd_dropped <= drop;
      overflow <= drop | (overflow & ~(status_wr & reg_wdata[8]));
      if (reg_read) reg_rdata <= rd_mux;
    end
  end

`ifdef GPU_CMD_IRQ_EN
  logic busy_q;
  // Idle interrupt raised on the busy falling edge; a same-cycle set beats the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      irq <= 1'b0;
    end else begin
      busy_q <= busy;
      irq <= (busy_q & ~busy) | (irq & ~(status_wr & reg_wdata[10]));
    end
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif
endmodule
